// File: rtl/alu_uart_sequencer_pkg.sv
// Shared definitions for the ALU front-end sequencer.
// The default data and mode widths are shared with the ALU and UART blocks.
// The state encodings are the 3-bit constants kept for older blocks that decode the state.
package alu_uart_sequencer_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_MODE_WIDTH = 6;
    localparam int unsigned STATE_WIDTH        = 3;

    localparam logic [STATE_WIDTH-1:0] S_WAIT_A  = 3'd0;
    localparam logic [STATE_WIDTH-1:0] S_WAIT_B  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] S_WAIT_OP = 3'd2;
    localparam logic [STATE_WIDTH-1:0] S_EXEC    = 3'd3;
    localparam logic [STATE_WIDTH-1:0] S_SEND    = 3'd4;
    localparam logic [STATE_WIDTH-1:0] S_WAIT_TX = 3'd5;

    // True in the middle of a command, where an idle gap between bytes may be aborted.
    function automatic logic in_timeout_window(input logic [STATE_WIDTH-1:0] state);
        return (state == S_WAIT_B) || (state == S_WAIT_OP);
    endfunction

    // True while a command is executing or transmitting, so incoming bytes are dropped.
    function automatic logic in_overrun_window(input logic [STATE_WIDTH-1:0] state);
        return (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Inter-byte idle counter for the sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count from zero (has priority over enable)
//   enable     : one idle cycle inside the timeout window
//   expire_c   : combinational; high on the idle cycle that completes TIMEOUT_CYCLES
// TIMEOUT_CYCLES = 0 disables the timeout, so expire_c is tied low.
module seq_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] cnt;

    // Saturating idle-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expire on the idle cycle that would take the count to TIMEOUT_CYCLES.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign expire_c = 1'b0;
        end else begin : g_enabled
            assign expire_c = enable && (cnt == CNT_W'(LAST));
        end
    endgenerate

endmodule

// File: rtl/alu_uart_sequencer.sv
// Front-end controller for the ALU datapath.
// It assembles operand A, operand B and the op code from the UART receive byte stream.
// It holds them on the ALU inputs, waits the ALU settle time, captures the result and
// hands it to the UART transmitter.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_rx_data/valid  : received byte and its one-cycle strobe
//   i_alu_result     : combinational ALU result for o_A/o_B/o_op
//   o_A, o_B, o_op   : registered ALU operands and op code
//   o_tx_data        : captured result byte for the transmitter
//   o_tx_start       : one-cycle transmit start pulse
//   i_tx_busy        : transmitter busy; high from the o_tx_start cycle onward
//   o_busy           : high whenever a command is in progress
//   o_timeout        : one-cycle pulse when a partial command is abandoned
//   o_overrun        : one-cycle pulse when a byte is dropped during execute/transmit
module alu_uart_sequencer
    import alu_uart_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned MODE_WIDTH     = DEFAULT_MODE_WIDTH,
    parameter int unsigned ALU_LATENCY    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic [DATA_WIDTH-1:0] o_A,
    output logic [DATA_WIDTH-1:0] o_B,
    output logic [MODE_WIDTH-1:0] o_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_busy,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    localparam int unsigned EXEC_W    = $clog2(ALU_LATENCY + 1);
    localparam int unsigned EXEC_LAST = (ALU_LATENCY == 0) ? 0 : ALU_LATENCY - 1;

    logic [STATE_WIDTH-1:0] state,    state_nxt;
    logic [EXEC_W-1:0]      exec_cnt, exec_cnt_nxt;
    logic [DATA_WIDTH-1:0]  a_nxt, b_nxt, tx_data_nxt;
    logic [MODE_WIDTH-1:0]  op_nxt;
    logic                   tx_start_nxt, busy_nxt, timeout_nxt, overrun_nxt;

    logic to_enable_c, to_clear_c, to_expire_c;

    // Count only idle cycles mid-command. Any byte or leaving the window restarts the count.
    assign to_enable_c = in_timeout_window(state) && !i_rx_valid;
    assign to_clear_c  = !to_enable_c;

    seq_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (to_clear_c),
        .enable   (to_enable_c),
        .expire_c (to_expire_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        exec_cnt_nxt = exec_cnt;
        a_nxt        = o_A;
        b_nxt        = o_B;
        op_nxt       = o_op;
        tx_data_nxt  = o_tx_data;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        overrun_nxt  = 1'b0;

        case (state)
            S_WAIT_A: begin
                if (i_rx_valid) begin
                    a_nxt     = i_rx_data;
                    state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_valid) begin
                    b_nxt     = i_rx_data;
                    state_nxt = S_WAIT_OP;
                end else if (to_expire_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_valid) begin
                    op_nxt       = i_rx_data[MODE_WIDTH-1:0];
                    exec_cnt_nxt = '0;
                    state_nxt    = S_EXEC;
                end else if (to_expire_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_WAIT_A;
                end
            end
            S_EXEC: begin
                // Operands have been stable for ALU_LATENCY cycles on the last count.
                if (exec_cnt == EXEC_W'(EXEC_LAST)) begin
                    tx_data_nxt = i_alu_result;
                    state_nxt   = S_SEND;
                end else if (exec_cnt != EXEC_W'(ALU_LATENCY)) begin
                    exec_cnt_nxt = exec_cnt + EXEC_W'(1);
                end
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    tx_start_nxt = 1'b1;
                    state_nxt    = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (!i_tx_busy) begin
                    state_nxt = S_WAIT_A;
                end
            end
            default: begin
                state_nxt = S_WAIT_A;
            end
        endcase

        if (in_overrun_window(state) && i_rx_valid) begin
            overrun_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != S_WAIT_A);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_WAIT_A;
            exec_cnt   <= '0;
            o_A        <= '0;
            o_B        <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_nxt;
            exec_cnt   <= exec_cnt_nxt;
            o_A        <= a_nxt;
            o_B        <= b_nxt;
            o_op       <= op_nxt;
            o_tx_data  <= tx_data_nxt;
            o_tx_start <= tx_start_nxt;
            o_busy     <= busy_nxt;
            o_timeout  <= timeout_nxt;
            o_overrun  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed testbench for alu_uart_sequencer.
// It provides a behavioural ALU (ADD/SUB) and a transmitter model that stays busy for 10 cycles.
module tb_alu_uart_sequencer;

    localparam int unsigned DW  = 8;
    localparam int unsigned MW  = 6;
    localparam int unsigned LAT = 2;
    localparam int unsigned TO  = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] a, b, tx_data;
    logic [MW-1:0] op;
    logic          tx_start, tx_busy, busy, timeout, overrun;
    logic          hold_busy;

    int checks = 0;
    int passed = 0;

    int unsigned tx_cnt = 0;
    int n_start   = 0;
    int n_timeout = 0;
    int n_overrun = 0;

    alu_uart_sequencer #(
        .DATA_WIDTH     (DW),
        .MODE_WIDTH     (MW),
        .ALU_LATENCY    (LAT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_alu_result (alu_result),
        .o_A          (a),
        .o_B          (b),
        .o_op         (op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_busy    (tx_busy),
        .o_busy       (busy),
        .o_timeout    (timeout),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        case (op)
            6'h20:   alu_result = a + b;
            6'h22:   alu_result = a - b;
            default: alu_result = 8'h00;
        endcase
    end

    // Transmitter model: busy during the start cycle plus 9 more cycles.
    always @(posedge clk) begin
        if (tx_start) tx_cnt <= 9;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = tx_start || (tx_cnt != 0) || hold_busy;

    // Pulse counters
    always @(posedge clk) begin
        if (tx_start) n_start   <= n_start + 1;
        if (timeout)  n_timeout <= n_timeout + 1;
        if (overrun)  n_overrun <= n_overrun + 1;
    end

    // Called just after a negedge; byte is sampled on the following posedge.
    task automatic send_byte(input logic [DW-1:0] v);
        rx_data  = v;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; hold_busy = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({a, b, op, tx_data, tx_start, busy, timeout, overrun} !== 34'd0) $display("FAIL reset_outputs: got %h expected 0", {a, b, op, tx_data, tx_start, busy, timeout, overrun}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_add();
        int s0, n;
        s0 = n_start;
        send_byte(8'h05);
        checks++; if (a !== 8'h05) $display("FAIL add_A: got %h expected 05", a); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL add_busy: got %b expected 1", busy); else passed++;
        send_byte(8'h03);
        checks++; if (b !== 8'h03) $display("FAIL add_B: got %h expected 03", b); else passed++;
        send_byte(8'h20);
        checks++; if (op !== 6'h20) $display("FAIL add_op: got %h expected 20", op); else passed++;
        @(negedge clk);
        checks++; if (tx_data !== 8'h00) $display("FAIL add_early_capture: got %h expected 00", tx_data); else passed++;
        @(negedge clk);
        checks++; if (tx_data !== 8'h08) $display("FAIL add_result: got %h expected 08", tx_data); else passed++;
        checks++; if (tx_start !== 1'b0) $display("FAIL add_start_early: got %b expected 0", tx_start); else passed++;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("FAIL add_start: got %b expected 1", tx_start); else passed++;
        wait_not_busy(n);
        checks++; if (n !== 11) $display("FAIL add_busy_fall: got %0d cycles expected 11", n); else passed++;
        checks++; if (n_start - s0 !== 1) $display("FAIL add_start_count: got %0d expected 1", n_start - s0); else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        send_byte(8'h02);
        send_byte(8'h07);
        send_byte(8'h22);
        checks++; if ({a, b, op} !== {8'h02, 8'h07, 6'h22}) $display("FAIL b2b_operands: got %h expected %h", {a, b, op}, {8'h02, 8'h07, 6'h22}); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("FAIL b2b_start: got %b expected 1", tx_start); else passed++;
        checks++; if (tx_data !== 8'hFB) $display("FAIL sub_result: got %h expected fb", tx_data); else passed++;
        checks++; if ({a, b, op} !== {8'h02, 8'h07, 6'h22}) $display("FAIL b2b_hold: got %h expected %h", {a, b, op}, {8'h02, 8'h07, 6'h22}); else passed++;
        wait_not_busy(n);
        checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", busy); else passed++;
        send_byte(8'h7F);
        send_byte(8'h01);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        checks++; if (tx_data !== 8'h80) $display("FAIL b2b_second_result: got %h expected 80", tx_data); else passed++;
        checks++; if (a !== 8'h7F) $display("FAIL b2b_second_A: got %h expected 7f", a); else passed++;
        wait_not_busy(n);
    endtask

    task automatic test_timeout();
        int t0, n;
        t0 = n_timeout;
        send_byte(8'h11);
        repeat (15) @(negedge clk);
        checks++; if (timeout !== 1'b0) $display("FAIL to_early: got %b expected 0", timeout); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL to_busy_before: got %b expected 1", busy); else passed++;
        @(negedge clk);
        checks++; if (timeout !== 1'b1) $display("FAIL to_pulse: got %b expected 1", timeout); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL to_wait_a: got %b expected 0", busy); else passed++;
        checks++; if ({a, b} !== {8'h11, 8'h01}) $display("FAIL to_regs_kept: got %h expected 1101", {a, b}); else passed++;
        @(negedge clk);
        checks++; if (timeout !== 1'b0) $display("FAIL to_pulse_width: got %b expected 0", timeout); else passed++;
        checks++; if (n_timeout - t0 !== 1) $display("FAIL to_count: got %0d expected 1", n_timeout - t0); else passed++;
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        checks++; if ({tx_start, tx_data} !== {1'b1, 8'h0D}) $display("FAIL to_fresh_cmd: got %h expected %h", {tx_start, tx_data}, {1'b1, 8'h0D}); else passed++;
        wait_not_busy(n);
        // B arrives on the 16th cycle after A: accepted, no timeout
        t0 = n_timeout;
        send_byte(8'h30);
        repeat (15) @(negedge clk);
        send_byte(8'h40);
        checks++; if (b !== 8'h40) $display("FAIL to_edge_B: got %h expected 40", b); else passed++;
        checks++; if ({busy, timeout} !== 2'b10) $display("FAIL to_edge_state: got %b expected 10", {busy, timeout}); else passed++;
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        checks++; if (tx_data !== 8'hF0) $display("FAIL to_edge_result: got %h expected f0", tx_data); else passed++;
        checks++; if (n_timeout - t0 !== 0) $display("FAIL to_edge_count: got %0d expected 0", n_timeout - t0); else passed++;
        wait_not_busy(n);
    endtask

    task automatic test_overrun();
        int o0, s0, n;
        o0 = n_overrun; s0 = n_start;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        send_byte(8'hAA);
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_exec_pulse: got %b expected 1", overrun); else passed++;
        checks++; if (a !== 8'h05) $display("FAIL ovr_exec_A: got %h expected 05", a); else passed++;
        @(negedge clk);
        checks++; if (overrun !== 1'b0) $display("FAIL ovr_pulse_width: got %b expected 0", overrun); else passed++;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("FAIL ovr_start: got %b expected 1", tx_start); else passed++;
        @(negedge clk);
        send_byte(8'hBB);
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_wait_tx_pulse: got %b expected 1", overrun); else passed++;
        wait_not_busy(n);
        checks++; if ({a, b, op, tx_data} !== {8'h05, 8'h03, 6'h20, 8'h08}) $display("FAIL ovr_unchanged: got %h expected %h", {a, b, op, tx_data}, {8'h05, 8'h03, 6'h20, 8'h08}); else passed++;
        checks++; if (n_overrun - o0 !== 2) $display("FAIL ovr_count: got %0d expected 2", n_overrun - o0); else passed++;
        checks++; if (n_start - s0 !== 1) $display("FAIL ovr_start_count: got %0d expected 1", n_start - s0); else passed++;
    endtask

    task automatic test_busy_hold();
        int s0, n;
        s0 = n_start;
        hold_busy = 1'b1;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h22);
        repeat (6) @(negedge clk);
        checks++; if (n_start - s0 !== 0) $display("FAIL hold_no_start: got %0d expected 0", n_start - s0); else passed++;
        checks++; if ({busy, tx_data} !== {1'b1, 8'h02}) $display("FAIL hold_state: got %h expected %h", {busy, tx_data}, {1'b1, 8'h02}); else passed++;
        hold_busy = 1'b0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("FAIL hold_release_start: got %b expected 1", tx_start); else passed++;
        wait_not_busy(n);
        checks++; if (n_start - s0 !== 1) $display("FAIL hold_start_count: got %0d expected 1", n_start - s0); else passed++;
    endtask

    task automatic test_reset_mid();
        int s0, t0, o0, n;
        s0 = n_start; t0 = n_timeout; o0 = n_overrun;
        send_byte(8'h01);
        send_byte(8'h02);
        rst_n = 1'b0;
        #1;
        checks++; if ({a, b, op, tx_data, tx_start, busy, timeout, overrun} !== 34'd0) $display("FAIL rst_mid_cmd: got %h expected 0", {a, b, op, tx_data, tx_start, busy, timeout, overrun}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_cmd_idle: got %b expected 0", busy); else passed++;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("FAIL rst_tx_start: got %b expected 1", tx_start); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({a, b, op, tx_data, tx_start, busy, timeout, overrun} !== 34'd0) $display("FAIL rst_mid_tx: got %h expected 0", {a, b, op, tx_data, tx_start, busy, timeout, overrun}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_tx_idle: got %b expected 0", busy); else passed++;
        checks++; if ({n_start - s0, n_timeout - t0, n_overrun - o0} !== {32'd1, 32'd0, 32'd0}) $display("FAIL rst_stray_pulses: got %0d/%0d/%0d expected 1/0/0", n_start - s0, n_timeout - t0, n_overrun - o0); else passed++;
        send_byte(8'h09);
        send_byte(8'h04);
        send_byte(8'h22);
        repeat (3) @(negedge clk);
        checks++; if ({tx_start, tx_data} !== {1'b1, 8'h05}) $display("FAIL rst_fresh_cmd: got %h expected %h", {tx_start, tx_data}, {1'b1, 8'h05}); else passed++;
        wait_not_busy(n);
        checks++; if (busy !== 1'b0) $display("FAIL rst_final_idle: got %b expected 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_timeout();
        test_overrun();
        test_busy_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, checks);
        $fatal(1);
    end

endmodule
